// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    CHECK,
    DISPENSE,
    REFUND,
    RELEASE
  } state_e;

  localparam int CREDIT_MAX  = 20;
  localparam int CREDIT_STEP = 4;

  localparam int SW_ADD4     = 0;
  localparam int SW_ADD8     = 1;
  localparam int SW_ADD12    = 2;
  localparam int SW_DISPENSE = 3;
  localparam int SW_REFUND   = 4;
  localparam int NUM_SW      = 5;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-FF synchronizer, counter debounce, registered rising-edge pulse.
module sw_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced input disagrees with the accepted
  // level; any agreeing cycle (a bounce) sends it back to zero.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = level_q;
  assign rise = rise_q;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit sequencer: button conditioning, priority arbiter, credit register,
// timed dispense and one-shot refund.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int DEB_CYCLES  = 500000,
  parameter int DISP_CYCLES = 25000000,
  parameter int PRICE       = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [4:0] SW,
  output logic [4:0] credit_o,
  output logic       dispense_o,
  output logic       refund_o,
  output logic [4:0] refund_amt_o,
  output logic       busy_o,
  output logic       deny_o
);

  localparam int TW = $clog2(DISP_CYCLES + 1);

  logic [NUM_SW-1:0] sw_level, sw_rise;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .din      (SW[i]),
      .dout     (sw_level[i]),
      .rise     (sw_rise[i])
    );
  end

  state_e        state_q, state_d;
  logic [5:0]    credit_q, credit_d;
  logic [5:0]    add_q, add_d;
  logic [5:0]    sum;
  logic [TW-1:0] timer_q, timer_d;
  logic          dispense_q, dispense_d;
  logic          refund_q, refund_d;
  logic [4:0]    refund_amt_q, refund_amt_d;
  logic          deny_q, deny_d;

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    add_d        = add_q;
    timer_d      = timer_q;
    dispense_d   = dispense_q;
    refund_d     = 1'b0;
    refund_amt_d = '0;
    deny_d       = 1'b0;
    sum          = credit_q + add_q;
    unique case (state_q)
      // Edges outside IDLE are simply never looked at, so they are dropped.
      IDLE: begin
        if (sw_rise[SW_REFUND])          state_d = REFUND;
        else if (sw_rise[SW_DISPENSE])   state_d = CHECK;
        else if (sw_rise[SW_ADD12]) begin add_d = 6'(3 * CREDIT_STEP); state_d = APPLY; end
        else if (sw_rise[SW_ADD8])  begin add_d = 6'(2 * CREDIT_STEP); state_d = APPLY; end
        else if (sw_rise[SW_ADD4])  begin add_d = 6'(CREDIT_STEP);     state_d = APPLY; end
      end
      APPLY: begin
        credit_d = (sum > 6'(CREDIT_MAX)) ? 6'(CREDIT_MAX) : sum;
        state_d  = RELEASE;
      end
      CHECK: begin
        if (credit_q >= 6'(PRICE)) begin
          credit_d   = credit_q - 6'(PRICE);
          timer_d    = TW'(DISP_CYCLES);
          dispense_d = 1'b1;
          state_d    = DISPENSE;
        end else begin
          deny_d  = 1'b1;
          state_d = RELEASE;
        end
      end
      DISPENSE: begin
        if (timer_q == TW'(1)) begin
          dispense_d = 1'b0;
          state_d    = RELEASE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      REFUND: begin
        refund_d     = 1'b1;
        refund_amt_d = credit_q[4:0];
        credit_d     = '0;
        state_d      = RELEASE;
      end
      RELEASE: begin
        if (sw_level == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      add_q        <= '0;
      timer_q      <= '0;
      dispense_q   <= 1'b0;
      refund_q     <= 1'b0;
      refund_amt_q <= '0;
      deny_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      add_q        <= add_d;
      timer_q      <= timer_d;
      dispense_q   <= dispense_d;
      refund_q     <= refund_d;
      refund_amt_q <= refund_amt_d;
      deny_q       <= deny_d;
    end
  end

  assign credit_o     = credit_q[4:0];
  assign dispense_o   = dispense_q;
  assign refund_o     = refund_q;
  assign refund_amt_o = refund_amt_q;
  assign deny_o       = deny_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl with short debounce and dispense times.
module tb_vend_credit_ctrl;

  logic       CLOCK_50;
  logic       reset;
  logic [4:0] SW;
  logic [4:0] credit_o;
  logic       dispense_o;
  logic       refund_o;
  logic [4:0] refund_amt_o;
  logic       busy_o;
  logic       deny_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  vend_credit_ctrl #(.DEB_CYCLES(4), .DISP_CYCLES(10), .PRICE(8)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .SW           (SW),
    .credit_o     (credit_o),
    .dispense_o   (dispense_o),
    .refund_o     (refund_o),
    .refund_amt_o (refund_amt_o),
    .busy_o       (busy_o),
    .deny_o       (deny_o)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Press mask for 10 cycles, observe 40 cycles, then score the outcome.
  // exp_lat >= 0 also checks the cycle on which credit_o first changes.
  task automatic run_cmd(input string tag, input logic [4:0] mask, input logic [4:0] exp_credit,
                         input int exp_disp, input int exp_deny, input int exp_ref,
                         input logic [4:0] exp_amt, input int exp_lat);
    int n_disp = 0;
    int n_deny = 0;
    int n_ref  = 0;
    int chg_at = -1;
    logic [4:0] amt   = '0;
    logic [4:0] start = credit_o;
    logic [4:0] exp;
    exp_q.push_back(exp_credit);
    SW = mask;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (dispense_o) n_disp++;
      if (deny_o)     n_deny++;
      if (refund_o) begin n_ref++; amt = refund_amt_o; end
      if (chg_at < 0 && credit_o != start) chg_at = i;
      if (i == 9) SW = '0;
    end
    exp = exp_q.pop_front();
    check({tag, ".credit"}, credit_o, exp);
    check({tag, ".disp_cycles"}, n_disp, exp_disp);
    check({tag, ".deny"}, n_deny, exp_deny);
    check({tag, ".refund"}, n_ref, exp_ref);
    check({tag, ".refund_amt"}, amt, exp_amt);
    check({tag, ".busy_end"}, busy_o, 0);
    if (exp_lat >= 0) check({tag, ".latency"}, chg_at, exp_lat);
  endtask

  initial begin
    int n_busy;
    int waited;
    SW    = '0;
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("rst.credit", credit_o, 0);
    check("rst.dispense", dispense_o, 0);
    check("rst.refund", refund_o, 0);
    check("rst.refund_amt", refund_amt_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.deny", deny_o, 0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    // 1: three +4 presses; credit changes 2 sync + 4 debounce + 1 apply edges later
    run_cmd("add4_a", 5'b00001, 5'd4,  0, 0, 0, 5'd0, 7);
    run_cmd("add4_b", 5'b00001, 5'd8,  0, 0, 0, 5'd0, 7);
    run_cmd("add4_c", 5'b00001, 5'd12, 0, 0, 0, 5'd0, 7);

    // 2: saturation at 20
    run_cmd("add4_d",  5'b00001, 5'd16, 0, 0, 0, 5'd0, -1);
    run_cmd("add12",   5'b00100, 5'd20, 0, 0, 0, 5'd0, -1);
    run_cmd("add8_sat", 5'b00010, 5'd20, 0, 0, 0, 5'd0, -1);

    // 3: dispense from 12, then denial at 4
    run_cmd("refund20", 5'b10000, 5'd0,  0, 0, 1, 5'd20, -1);
    run_cmd("add12_b",  5'b00100, 5'd12, 0, 0, 0, 5'd0, -1);
    run_cmd("disp",     5'b01000, 5'd4,  10, 0, 0, 5'd0, -1);
    run_cmd("deny",     5'b01000, 5'd4,  0, 1, 0, 5'd0, -1);

    // 5: bouncing SW0 never settles
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      SW[0] = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
      @(negedge CLOCK_50);
      if (busy_o) n_busy++;
    end
    check("bounce.credit", credit_o, 4);
    check("bounce.busy_cycles", n_busy, 0);

    // 4: simultaneous SW0+SW3+SW4 -> refund wins; then refund at zero
    run_cmd("add4_e",    5'b00001, 5'd8, 0, 0, 0, 5'd0, -1);
    run_cmd("multi",     5'b11001, 5'd0, 0, 0, 1, 5'd8, -1);
    run_cmd("refund0",   5'b10000, 5'd0, 0, 0, 1, 5'd0, -1);

    // 6: reset in the middle of a dispense
    run_cmd("add12_c", 5'b00100, 5'd12, 0, 0, 0, 5'd0, -1);
    SW = 5'b01000;
    waited = 0;
    while (!dispense_o && waited < 30) begin
      @(negedge CLOCK_50);
      waited++;
    end
    check("mid.dispense_seen", dispense_o, 1);
    SW = '0;
    repeat (4) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("mid.dispense", dispense_o, 0);
    check("mid.credit", credit_o, 0);
    check("mid.busy", busy_o, 0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    run_cmd("post_rst", 5'b00001, 5'd4, 0, 0, 0, 5'd0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
